regfile_read_arb: RTL and testbench

Round-robin arbiter that shares the register file's single pair of operand lookup ports (get_reg_1/2) between NUM_REQ requesters, such as decode slots and a replay path. It grants one requester per cycle and drives its rs1/rs2 to the register file. The looked-up value/dependency pair is registered and returned to that requester one cycle later. It patches the response with the same-cycle issue rename, which the register file does not yet reflect.

---
 rtl/regfile_read_arb_pkg.sv | 6 +
 rtl/regfile_read_arb_rr_arbiter.sv | 26 ++
 rtl/regfile_read_arb.sv | 82 ++++++++
 tb/tb_regfile_read_arb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_read_arb_pkg.sv
// regfile_read_arb_pkg: shared widths and defaults for the regfile read arbiter
package regfile_read_arb_pkg;
  localparam int ROB_WIDTH = 4;
  localparam int REG_ID_WIDTH = 5;
  localparam int NUM_READ_REQ = 3;
endpackage

// File: rtl/regfile_read_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] idx;
  always_comb begin
    idx = '0;
    winner = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        winner = idx;
        any = 1'b1;
      end
    end
    grant = any ? N'(1) << winner : '0;
  end
endmodule

// File: rtl/regfile_read_arb.sv
// regfile_read_arb: round-robin sharing of the regfile operand lookup ports
module regfile_read_arb #(
  parameter int NUM_REQ = regfile_read_arb_pkg::NUM_READ_REQ,
  parameter int ROB_WIDTH = regfile_read_arb_pkg::ROB_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           clear,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [5*NUM_REQ-1:0]           req_rs1,
  input  logic [5*NUM_REQ-1:0]           req_rs2,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [32*NUM_REQ-1:0]          rsp_val1,
  output logic [NUM_REQ-1:0]             rsp_has_dep1,
  output logic [ROB_WIDTH*NUM_REQ-1:0]   rsp_dep1,
  output logic [32*NUM_REQ-1:0]          rsp_val2,
  output logic [NUM_REQ-1:0]             rsp_has_dep2,
  output logic [ROB_WIDTH*NUM_REQ-1:0]   rsp_dep2,
  output logic [4:0]                     get_reg_1,
  input  logic [31:0]                    get_val_1,
  input  logic                           has_dep_1,
  input  logic [ROB_WIDTH-1:0]           get_dep_1,
  output logic [4:0]                     get_reg_2,
  input  logic [31:0]                    get_val_2,
  input  logic                           has_dep_2,
  input  logic [ROB_WIDTH-1:0]           get_dep_2,
  input  logic [4:0]                     issue_reg_id,
  input  logic [ROB_WIDTH-1:0]           issue_rob_id
);
  import regfile_read_arb_pkg::*;
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] rr_ptr, win;
  logic [NUM_REQ-1:0] grant;
  logic any, go, pat1, pat2, hd1, hd2;
  logic [31:0] val1, val2;
  logic [ROB_WIDTH-1:0] dep1, dep2;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .winner(win),
    .any(any)
  );
  assign go = rst_in && rdy_in && !clear && any;
  assign req_ready = go ? grant : '0;
  assign get_reg_1 = go ? req_rs1[win*REG_ID_WIDTH +: REG_ID_WIDTH] : '0;
  assign get_reg_2 = go ? req_rs2[win*REG_ID_WIDTH +: REG_ID_WIDTH] : '0;
  // The regfile does not yet see this cycle's rename, so it overrides the dependency
  assign pat1 = issue_reg_id != '0 && issue_reg_id == get_reg_1;
  assign pat2 = issue_reg_id != '0 && issue_reg_id == get_reg_2;
  assign val1 = get_reg_1 == '0 ? '0 : get_val_1;
  assign val2 = get_reg_2 == '0 ? '0 : get_val_2;
  assign hd1 = get_reg_1 != '0 && (pat1 || has_dep_1);
  assign hd2 = get_reg_2 != '0 && (pat2 || has_dep_2);
  assign dep1 = get_reg_1 == '0 ? '0 : pat1 ? issue_rob_id : get_dep_1;
  assign dep2 = get_reg_2 == '0 ? '0 : pat2 ? issue_rob_id : get_dep_2;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr <= '0;
      rsp_valid <= '0;
      rsp_val1 <= '0;
      rsp_has_dep1 <= '0;
      rsp_dep1 <= '0;
      rsp_val2 <= '0;
      rsp_has_dep2 <= '0;
      rsp_dep2 <= '0;
    end else if (rdy_in) begin
      rsp_valid <= req_ready;
      if (go) begin
        rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        rsp_val1[win*32 +: 32] <= val1;
        rsp_has_dep1[win] <= hd1;
        rsp_dep1[win*ROB_WIDTH +: ROB_WIDTH] <= dep1;
        rsp_val2[win*32 +: 32] <= val2;
        rsp_has_dep2[win] <= hd2;
        rsp_dep2[win*ROB_WIDTH +: ROB_WIDTH] <= dep2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_read_arb.sv
// tb_regfile_read_arb: directed scenarios plus randomized run against a reference model
module tb_regfile_read_arb;
  localparam int N = 3;
  localparam int RW = 4;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [5*N-1:0] req_rs1 = '0, req_rs2 = '0;
  logic [N-1:0] req_ready, rsp_valid, rsp_has_dep1, rsp_has_dep2;
  logic [32*N-1:0] rsp_val1, rsp_val2;
  logic [RW*N-1:0] rsp_dep1, rsp_dep2;
  logic [4:0] get_reg_1, get_reg_2;
  logic [31:0] get_val_1 = '0, get_val_2 = '0;
  logic has_dep_1 = 1'b0, has_dep_2 = 1'b0;
  logic [RW-1:0] get_dep_1 = '0, get_dep_2 = '0;
  logic [4:0] issue_reg_id = '0;
  logic [RW-1:0] issue_rob_id = '0;
  int n_pass = 0;
  int n_tot = 0;
  int m_ptr;
  logic [N-1:0] m_rv;
  logic [31:0] m_v1 [N];
  logic [31:0] m_v2 [N];
  logic m_h1 [N];
  logic m_h2 [N];
  logic [RW-1:0] m_d1 [N];
  logic [RW-1:0] m_d2 [N];

  always #5 clk_in = ~clk_in;

  regfile_read_arb #(.NUM_REQ(N), .ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .req_valid(req_valid), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_val1(rsp_val1), .rsp_has_dep1(rsp_has_dep1), .rsp_dep1(rsp_dep1),
    .rsp_val2(rsp_val2), .rsp_has_dep2(rsp_has_dep2), .rsp_dep2(rsp_dep2),
    .get_reg_1(get_reg_1), .get_val_1(get_val_1), .has_dep_1(has_dep_1), .get_dep_1(get_dep_1),
    .get_reg_2(get_reg_2), .get_val_2(get_val_2), .has_dep_2(has_dep_2), .get_dep_2(get_dep_2),
    .issue_reg_id(issue_reg_id), .issue_rob_id(issue_rob_id)
  );

  function automatic int exp_win();
    if (!rst_in || !rdy_in || clear) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_rv = '0;
    for (int i = 0; i < N; i++) begin
      m_v1[i] = '0; m_v2[i] = '0; m_h1[i] = 1'b0; m_h2[i] = 1'b0; m_d1[i] = '0; m_d2[i] = '0;
    end
  endtask

  task automatic cap(input logic [4:0] rs, input logic [31:0] v, input logic h, input logic [RW-1:0] d,
                     output logic [31:0] ov, output logic oh, output logic [RW-1:0] od);
    if (rs == 5'd0) begin
      ov = '0; oh = 1'b0; od = '0;
    end else if (issue_reg_id != 5'd0 && issue_reg_id == rs) begin
      ov = v; oh = 1'b1; od = issue_rob_id;
    end else begin
      ov = v; oh = h; od = d;
    end
  endtask

  task automatic model_edge();
    int w;
    w = exp_win();
    if (!rst_in) model_reset();
    else if (rdy_in) begin
      m_rv = '0;
      if (w >= 0) begin
        m_rv[w] = 1'b1;
        m_ptr = (w + 1) % N;
        cap(req_rs1[w*5 +: 5], get_val_1, has_dep_1, get_dep_1, m_v1[w], m_h1[w], m_d1[w]);
        cap(req_rs2[w*5 +: 5], get_val_2, has_dep_2, get_dep_2, m_v2[w], m_h2[w], m_d2[w]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    req_rs1 = {5'd3, 5'd2, 5'd1};
    req_rs2 = {5'd6, 5'd5, 5'd4};
    get_val_1 = 32'hdead_beef;
    get_val_2 = 32'h0bad_f00d;
    #2;
    n_tot++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready); else n_pass++;
    n_tot++; if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); else n_pass++;
    tick();
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tot++; if (req_ready !== 3'(1 << (k % N))) $display("FAIL reset_order%0d got %b want %b", k, req_ready, 3'(1 << (k % N))); else n_pass++;
      tick();
    end
    #1 rst_in = 1'b0;
    model_reset();
    #1;
    n_tot++; if (rsp_valid !== 3'b000) $display("FAIL midreset_rsp_valid got %b want 000", rsp_valid); else n_pass++;
    n_tot++; if (req_ready !== 3'b000) $display("FAIL midreset_ready got %b want 000", req_ready); else n_pass++;
    n_tot++; if (rsp_val1 !== '0) $display("FAIL midreset_val1 got %h want 0", rsp_val1); else n_pass++;
    tick();
    rst_in = 1'b1;
    #1;
    n_tot++; if (req_ready !== 3'b001) $display("FAIL midreset_ptr got %b want 001", req_ready); else n_pass++;
    tick();
  endtask

  task automatic test_single();
    req_valid = 3'b010;
    req_rs1 = {5'd0, 5'd5, 5'd0};
    req_rs2 = '0;
    get_val_1 = 32'h1234; has_dep_1 = 1'b0; get_dep_1 = 4'd3;
    get_val_2 = 32'hffff; has_dep_2 = 1'b1; get_dep_2 = 4'd6;
    issue_reg_id = '0;
    #1;
    n_tot++; if (req_ready !== 3'b010) $display("FAIL single_ready got %b want 010", req_ready); else n_pass++;
    n_tot++; if (get_reg_1 !== 5'd5) $display("FAIL single_get_reg_1 got %0d want 5", get_reg_1); else n_pass++;
    n_tot++; if (get_reg_2 !== 5'd0) $display("FAIL single_get_reg_2 got %0d want 0", get_reg_2); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_tot++; if (rsp_valid !== 3'b010) $display("FAIL single_rsp_valid got %b want 010", rsp_valid); else n_pass++;
    n_tot++; if (rsp_val1[63:32] !== 32'h1234) $display("FAIL single_val1 got %h want 1234", rsp_val1[63:32]); else n_pass++;
    n_tot++; if (rsp_has_dep1[1] !== 1'b0) $display("FAIL single_has_dep1 got %b want 0", rsp_has_dep1[1]); else n_pass++;
    n_tot++; if (rsp_val2[63:32] !== 32'h0) $display("FAIL single_val2 got %h want 0", rsp_val2[63:32]); else n_pass++;
    n_tot++; if (rsp_has_dep2[1] !== 1'b0) $display("FAIL single_has_dep2 got %b want 0", rsp_has_dep2[1]); else n_pass++;
    tick();
    #1;
    n_tot++; if (rsp_valid !== 3'b000) $display("FAIL single_pulse_end got %b want 000", rsp_valid); else n_pass++;
  endtask

  task automatic test_patch();
    req_valid = 3'b001;
    req_rs1 = {5'd0, 5'd0, 5'd7};
    req_rs2 = {5'd0, 5'd0, 5'd8};
    get_val_1 = 32'h55; has_dep_1 = 1'b0; get_dep_1 = 4'd2;
    get_val_2 = 32'h66; has_dep_2 = 1'b1; get_dep_2 = 4'd4;
    issue_reg_id = 5'd7; issue_rob_id = 4'd9;
    tick();
    req_valid = '0;
    issue_reg_id = '0;
    #1;
    n_tot++; if (rsp_has_dep1[0] !== 1'b1) $display("FAIL patch_has_dep1 got %b want 1", rsp_has_dep1[0]); else n_pass++;
    n_tot++; if (rsp_dep1[3:0] !== 4'd9) $display("FAIL patch_dep1 got %0d want 9", rsp_dep1[3:0]); else n_pass++;
    n_tot++; if (rsp_val1[31:0] !== 32'h55) $display("FAIL patch_val1 got %h want 55", rsp_val1[31:0]); else n_pass++;
    n_tot++; if (rsp_dep2[3:0] !== 4'd4) $display("FAIL patch_dep2 got %0d want 4", rsp_dep2[3:0]); else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    int start;
    int cnt [N];
    start = m_ptr;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    req_valid = 3'b111;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) req_valid = '0;
      #1;
      if (k < 6) begin
        n_tot++; if (req_ready !== 3'(1 << ((start + k) % N))) $display("FAIL fair_grant%0d got %b want %b", k, req_ready, 3'(1 << ((start + k) % N))); else n_pass++;
      end
      if (k > 0) begin
        n_tot++; if (rsp_valid !== 3'(1 << ((start + k - 1) % N))) $display("FAIL fair_rsp%0d got %b want %b", k, rsp_valid, 3'(1 << ((start + k - 1) % N))); else n_pass++;
        for (int i = 0; i < N; i++) cnt[i] += int'(rsp_valid[i]);
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      n_tot++; if (cnt[i] != 2) $display("FAIL fair_count%0d got %0d want 2", i, cnt[i]); else n_pass++;
    end
  endtask

  task automatic test_clear();
    int p, e;
    p = m_ptr;
    e = (p == 0) ? 0 : 2;
    req_valid = 3'b101;
    clear = 1'b1;
    #1;
    n_tot++; if (req_ready !== 3'b000) $display("FAIL clear_ready got %b want 000", req_ready); else n_pass++;
    tick();
    clear = 1'b0;
    #1;
    n_tot++; if (rsp_valid !== 3'b000) $display("FAIL clear_rsp got %b want 000", rsp_valid); else n_pass++;
    n_tot++; if (req_ready !== 3'(1 << e)) $display("FAIL clear_ptr_kept got %b want %b", req_ready, 3'(1 << e)); else n_pass++;
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    req_valid = 3'b100;
    req_rs1 = {5'd3, 5'd0, 5'd0};
    get_val_1 = 32'hcafe;
    issue_reg_id = '0;
    #1;
    n_tot++; if (req_ready !== 3'b100) $display("FAIL stall_grant got %b want 100", req_ready); else n_pass++;
    tick();
    rdy_in = 1'b0;
    req_valid = 3'b011;
    get_val_1 = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tot++; if (rsp_valid !== 3'b100) $display("FAIL stall_hold%0d got %b want 100", k, rsp_valid); else n_pass++;
      n_tot++; if (rsp_val1[95:64] !== 32'hcafe) $display("FAIL stall_data%0d got %h want cafe", k, rsp_val1[95:64]); else n_pass++;
      n_tot++; if (req_ready !== 3'b000) $display("FAIL stall_nogrant%0d got %b want 000", k, req_ready); else n_pass++;
      tick();
    end
    rdy_in = 1'b1;
    req_valid = '0;
    #1;
    n_tot++; if (rsp_valid !== 3'b100) $display("FAIL stall_last got %b want 100", rsp_valid); else n_pass++;
    tick();
    #1;
    n_tot++; if (rsp_valid !== 3'b000) $display("FAIL stall_drop got %b want 000", rsp_valid); else n_pass++;
  endtask

  task automatic test_random();
    int w;
    logic [32*N-1:0] ev1, ev2;
    logic [RW*N-1:0] ed1, ed2;
    logic [N-1:0] eh1, eh2;
    for (int c = 0; c < 300; c++) begin
      rdy_in = $urandom_range(0, 9) != 0;
      clear = $urandom_range(0, 9) == 0;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_rs1[i*5 +: 5] = 5'($urandom_range(0, 7));
        req_rs2[i*5 +: 5] = 5'($urandom_range(0, 7));
      end
      get_val_1 = $urandom; get_val_2 = $urandom;
      has_dep_1 = 1'($urandom); has_dep_2 = 1'($urandom);
      get_dep_1 = RW'($urandom); get_dep_2 = RW'($urandom);
      issue_reg_id = 5'($urandom_range(0, 7));
      issue_rob_id = RW'($urandom);
      #1;
      w = exp_win();
      for (int i = 0; i < N; i++) begin
        ev1[i*32 +: 32] = m_v1[i]; ev2[i*32 +: 32] = m_v2[i];
        ed1[i*RW +: RW] = m_d1[i]; ed2[i*RW +: RW] = m_d2[i];
        eh1[i] = m_h1[i]; eh2[i] = m_h2[i];
      end
      n_tot++; if (req_ready !== (w < 0 ? 3'b000 : 3'(1 << w))) $display("FAIL rnd_ready c%0d got %b want win %0d", c, req_ready, w); else n_pass++;
      n_tot++; if (get_reg_1 !== (w < 0 ? 5'd0 : req_rs1[w*5 +: 5])) $display("FAIL rnd_get_reg_1 c%0d got %0d", c, get_reg_1); else n_pass++;
      n_tot++; if (get_reg_2 !== (w < 0 ? 5'd0 : req_rs2[w*5 +: 5])) $display("FAIL rnd_get_reg_2 c%0d got %0d", c, get_reg_2); else n_pass++;
      n_tot++; if (rsp_valid !== m_rv) $display("FAIL rnd_rsp_valid c%0d got %b want %b", c, rsp_valid, m_rv); else n_pass++;
      n_tot++; if ({rsp_val1, rsp_val2} !== {ev1, ev2}) $display("FAIL rnd_vals c%0d got %h %h want %h %h", c, rsp_val1, rsp_val2, ev1, ev2); else n_pass++;
      n_tot++; if ({rsp_has_dep1, rsp_has_dep2, rsp_dep1, rsp_dep2} !== {eh1, eh2, ed1, ed2}) $display("FAIL rnd_deps c%0d got %b %b %h %h want %b %b %h %h", c, rsp_has_dep1, rsp_has_dep2, rsp_dep1, rsp_dep2, eh1, eh2, ed1, ed2); else n_pass++;
      tick();
    end
    rdy_in = 1'b1;
    clear = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_patch();
    test_fairness();
    test_clear();
    test_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
